irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt front end sitting directly upstream of the PC/interrupt-nesting stage.
- Synchronises and debounces three asynchronous request lines (board buttons), then latches them as pending.
- Arbitrates by priority against the currently in-service level and drives the PC's three interrupt request inputs with a request/acknowledge handshake.
- Keeps an in-service mirror from the PC's running flags and the decoder's done pulses, and counts lost requests.

Parameters:
SYNC_STAGES, 2, synchroniser flops per request line (>=2)
DEBOUNCE_CYCLES, 16, consecutive stable synced cycles needed before the debounced level changes (>=1)
ACK_TIMEOUT, 64, cycles int_req may stay high without acknowledge before it is abandoned (>=2)
CNT_W, 8, width of drop_cnt

Ports:
clk  in  1  system clock; everything is on posedge
rst  in  1  reset, synchronous, active-high
irq_raw  in  3  asynchronous request lines; bit0=level1 (lowest), bit2=level3 (highest)
irq_mask  in  3  1 = level enabled
running  in  3  in-service flags from PC (interrupt1..3_running); used as acknowledge
done  in  3  one-cycle service-complete pulses from decode (interrupt1..3_done)
int_req  out  3  one-hot request to PC (interrupt1..3)
pending  out  3  latched, not-yet-acknowledged requests
in_service  out  3  mirror of levels currently being serviced
active_level  out  2  highest set in_service index, 1..3; 0 if none
busy  out  1  FSM in REQ state
drop_cnt  out  CNT_W  lost-request counter, saturating

Behaviour:
- Reset values: int_req=0, pending=0, in_service=0, active_level=0, busy=0, drop_cnt=0. Also cleared: synchroniser flops, debounce counters, debounced levels, FSM=IDLE. Reset asserted mid-REQ drops the request; int_req is 0 in the cycle after reset is sampled.
- Sync: each irq_raw bit passes through SYNC_STAGES flops.
- Debounce, per line:
  - Counter increments while synced value != debounced value; it resets to 0 when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch, the debounced value takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Event: rising edge of debounced line n, one cycle wide.
  - Masked (irq_mask[n]=0): event discarded and not counted.
  - Unmasked with pending[n]=0 and in_service[n]=0: set pending[n].
  - Otherwise: drop_cnt+1.
- Ack: a rising edge of running[n] sets in_service[n] and clears pending[n].
  - Event and ack on the same level in the same cycle: ack applies; the event is dropped and counted.
- in_service[n] clears on done[n] or on a falling edge of running[n]. done[n] with in_service[n]=0 is ignored. Set and clear in the same cycle: clear wins.
- Masking an already-pending level keeps pending set but makes it ineligible.
- Arbitration candidate: highest n with pending[n] & irq_mask[n] & (n > active_level).
- FSM:
  - IDLE: if a candidate exists, next cycle go to REQ with int_req = onehot(candidate) and the timeout counter cleared. Otherwise int_req=0.
  - REQ: int_req held constant and busy=1; a newly arriving higher level does not replace the outstanding request.
    - running[n] rises for the requested n: next cycle int_req=0, go to IDLE.
    - Timeout counter reaches ACK_TIMEOUT-1: clear pending[n], drop_cnt+1, int_req=0, go to IDLE.
    - rst: go to IDLE.
  - After returning to IDLE there is at least one IDLE cycle before the next request.
- Latency: the first debounced-high cycle raises pending in the next cycle; int_req follows one cycle later. From a clean irq_raw rise, int_req rises SYNC_STAGES + DEBOUNCE_CYCLES + 2 cycles later.
- drop_cnt saturates at all-ones; increments from several sources in one cycle add, then saturate.

Test Plan:
- DEBOUNCE_CYCLES=4, SYNC_STAGES=2. irq_raw[0] held high from cycle 0, mask=111 -> pending[0]=1 at cycle 7, int_req=001 at cycle 8. running[0] rise -> int_req=000, pending[0]=0, in_service=001, active_level=1.
- 3-cycle pulse on irq_raw[1] -> no pending, no int_req, drop_cnt unchanged.
- Level1 in service; level3 event -> int_req=100. Ack, then done[2] -> in_service=001, active_level=1. A level1 event meanwhile -> drop_cnt=1.
- Levels 1 and 3 become pending in the same cycle, none in service -> int_req=100 first; after ack, level1 is not issued (1 < active_level 3) until done[2].
- ACK_TIMEOUT=8, running never rises -> int_req high exactly 8 cycles, then 0, pending cleared, drop_cnt=1. drop_cnt driven past 255 with CNT_W=8 -> stays 255.
- rst asserted while busy=1 -> the cycle after: int_req=0, pending=0, in_service=0, drop_cnt=0. A masked event -> nothing latched; unmasking later issues nothing.

Source files
------------

// File: rtl/irq_controller_if.sv
// Request/status bundle between the board-side interrupt lines, the PC
// interrupt-nesting stage and the irq_controller front end.
interface irq_controller_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       irq_raw;
    logic [2:0]       irq_mask;
    logic [2:0]       running;
    logic [2:0]       done;
    logic [2:0]       int_req;
    logic [2:0]       pending;
    logic [2:0]       in_service;
    logic [1:0]       active_level;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;

    // Controller side
    modport slave (
        input  irq_raw, irq_mask, running, done,
        output int_req, pending, in_service, active_level, busy, drop_cnt
    );

    // Environment side (board lines, PC, decoder)
    modport master (
        output irq_raw, irq_mask, running, done,
        input  int_req, pending, in_service, active_level, busy, drop_cnt
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt front end: synchronise/debounce three request lines, latch them as
// pending, arbitrate against the in-service level and handshake with the PC.
module irq_controller #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 64,
    parameter int CNT_W           = 8
) (
    input  logic           clk,
    input  logic           rst,
    irq_controller_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(ACK_TIMEOUT);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [SYNC_STAGES-1:0][2:0] r_sync;
    logic [2:0]       w_synced;
    logic [2:0]       r_deb;
    logic [2:0]       r_deb_d;
    logic [DB_W-1:0]  r_db_cnt [3];
    logic [2:0]       w_event;
    logic [2:0]       r_run_d;
    logic [2:0]       w_run_rise;
    logic [2:0]       w_run_fall;
    logic [2:0]       r_pending;
    logic [2:0]       w_pending_nxt;
    logic [2:0]       r_in_service;
    logic [2:0]       w_in_service_nxt;
    logic [1:0]       w_active;
    logic [2:0]       w_cand;
    logic [CNT_W-1:0] r_drop;
    logic [CNT_W-1:0] w_drop_nxt;
    logic [2:0]       w_drop_inc;
    logic [CNT_W+2:0] w_drop_sum;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_req;
    logic [2:0]       w_req_nxt;
    logic [TO_W-1:0]  r_tmo;
    logic [TO_W-1:0]  w_tmo_nxt;
    logic             w_tmo_fire;

    assign w_synced   = r_sync[SYNC_STAGES-1];
    assign w_event    = r_deb & ~r_deb_d;
    assign w_run_rise = bus.running & ~r_run_d;
    assign w_run_fall = ~bus.running & r_run_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_run_d <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.irq_raw};
            r_run_d <= bus.running;
        end
    end

    // The debounced level only flips after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb   <= '0;
            r_deb_d <= '0;
            for (int unsigned i = 0; i < 3; i++) r_db_cnt[i] <= '0;
        end else begin
            r_deb_d <= r_deb;
            for (int unsigned i = 0; i < 3; i++) begin
                if (w_synced[i] != r_deb[i]) begin
                    if (r_db_cnt[i] == DB_MAX) begin
                        r_deb[i]    <= w_synced[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        w_active = 2'd0;
        if (r_in_service[2])      w_active = 2'd3;
        else if (r_in_service[1]) w_active = 2'd2;
        else if (r_in_service[0]) w_active = 2'd1;
    end

    // Highest eligible level strictly above the level currently being serviced.
    always_comb begin
        logic [2:0] elig;
        elig = '0;
        for (int unsigned i = 0; i < 3; i++)
            elig[i] = r_pending[i] & bus.irq_mask[i] & (2'(i + 1) > w_active);
        w_cand = '0;
        if (elig[2])      w_cand = 3'b100;
        else if (elig[1]) w_cand = 3'b010;
        else if (elig[0]) w_cand = 3'b001;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_req   <= '0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_tmo_nxt   = r_tmo;
        w_tmo_fire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = '0;
                if (w_cand != '0) begin
                    w_state_nxt = S_REQ;
                    w_req_nxt   = w_cand;
                    w_tmo_nxt   = '0;
                end
            end
            S_REQ: begin
                if ((w_run_rise & r_req) != '0) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = '0;
                end else if (r_tmo == TO_MAX) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = '0;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = '0;
            end
        endcase
    end

    // Ack beats a same-cycle event (event counted as lost); clear beats set for in_service.
    always_comb begin
        w_pending_nxt    = r_pending;
        w_in_service_nxt = r_in_service;
        w_drop_inc       = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (w_tmo_fire && r_req[i]) begin
                w_pending_nxt[i] = 1'b0;
                w_drop_inc       = w_drop_inc + 3'd1;
            end
            if (w_run_rise[i]) begin
                w_pending_nxt[i]    = 1'b0;
                w_in_service_nxt[i] = 1'b1;
            end
            if (w_event[i] && bus.irq_mask[i]) begin
                if (w_run_rise[i] || r_pending[i] || r_in_service[i])
                    w_drop_inc = w_drop_inc + 3'd1;
                else
                    w_pending_nxt[i] = 1'b1;
            end
            if ((bus.done[i] && r_in_service[i]) || w_run_fall[i])
                w_in_service_nxt[i] = 1'b0;
        end
    end

    always_comb begin
        w_drop_sum = {3'b000, r_drop} + (CNT_W+3)'(w_drop_inc);
        if (w_drop_sum > {3'b000, {CNT_W{1'b1}}})
            w_drop_nxt = '1;
        else
            w_drop_nxt = w_drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= '0;
            r_in_service <= '0;
            r_drop       <= '0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
            r_drop       <= w_drop_nxt;
        end
    end

    assign bus.int_req      = r_req;
    assign bus.pending      = r_pending;
    assign bus.in_service   = r_in_service;
    assign bus.active_level = w_active;
    assign bus.busy         = (r_state == S_REQ);
    assign bus.drop_cnt     = r_drop;
endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// ACK_TIMEOUT=8, CNT_W=8: vector table plus hand-written saturation/reset sequences.
module tb_irq_controller;
    logic clk = 1'b0;
    logic rst;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    irq_controller_if #(.CNT_W(8)) bus ();

    irq_controller #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .ACK_TIMEOUT    (8),
        .CNT_W          (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  raw;
        logic [2:0]  mask;
        logic [2:0]  run;
        logic [2:0]  dn;
        int unsigned n;
        logic [2:0]  e_req;
        logic [2:0]  e_pend;
        logic [2:0]  e_isv;
        logic [1:0]  e_act;
        logic        e_busy;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input string name, input logic r, input logic [2:0] raw,
                                input logic [2:0] mask, input logic [2:0] run,
                                input logic [2:0] dn, input int unsigned n,
                                input logic [2:0] e_req, input logic [2:0] e_pend,
                                input logic [2:0] e_isv, input logic [1:0] e_act,
                                input logic e_busy, input logic [7:0] e_drop);
        vec_t v;
        v.name = name; v.rst = r; v.raw = raw; v.mask = mask; v.run = run; v.dn = dn;
        v.n = n; v.e_req = e_req; v.e_pend = e_pend; v.e_isv = e_isv; v.e_act = e_act;
        v.e_busy = e_busy; v.e_drop = e_drop;
        return v;
    endfunction

    // Drive inputs just after an edge, then let n rising edges pass and settle.
    task automatic apply(input logic r, input logic [2:0] raw, input logic [2:0] mask,
                         input logic [2:0] run, input logic [2:0] dn, input int unsigned n);
        rst          = r;
        bus.irq_raw  = raw;
        bus.irq_mask = mask;
        bus.running  = run;
        bus.done     = dn;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] e_req, input logic [2:0] e_pend,
                         input logic [2:0] e_isv, input logic [1:0] e_act,
                         input logic e_busy, input logic [7:0] e_drop);
        n_tests++;
        if (bus.int_req !== e_req || bus.pending !== e_pend || bus.in_service !== e_isv ||
            bus.active_level !== e_act || bus.busy !== e_busy || bus.drop_cnt !== e_drop) begin
            n_fail++;
            $display("FAIL %s: got req=%b pend=%b isv=%b act=%0d busy=%b drop=%0d, expected req=%b pend=%b isv=%b act=%0d busy=%b drop=%0d",
                     name, bus.int_req, bus.pending, bus.in_service, bus.active_level,
                     bus.busy, bus.drop_cnt, e_req, e_pend, e_isv, e_act, e_busy, e_drop);
        end
    endtask

    initial begin
        // name, rst, raw, mask, run, done, cycles | req, pend, isv, act, busy, drop
        vt.push_back(mk("reset",        1, 3'b000, 3'b111, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vt.push_back(mk("l1_settling",  0, 3'b001, 3'b111, 3'b000, 3'b000, 6, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vt.push_back(mk("l1_pending",   0, 3'b001, 3'b111, 3'b000, 3'b000, 1, 3'b000, 3'b001, 3'b000, 0, 0, 0));
        vt.push_back(mk("l1_req",       0, 3'b001, 3'b111, 3'b000, 3'b000, 1, 3'b001, 3'b001, 3'b000, 0, 1, 0));
        vt.push_back(mk("l1_ack",       0, 3'b001, 3'b111, 3'b001, 3'b000, 1, 3'b000, 3'b000, 3'b001, 1, 0, 0));
        vt.push_back(mk("glitch_on",    0, 3'b011, 3'b111, 3'b001, 3'b000, 3, 3'b000, 3'b000, 3'b001, 1, 0, 0));
        vt.push_back(mk("glitch_after", 0, 3'b001, 3'b111, 3'b001, 3'b000, 10, 3'b000, 3'b000, 3'b001, 1, 0, 0));
        vt.push_back(mk("l3_pending",   0, 3'b101, 3'b111, 3'b001, 3'b000, 7, 3'b000, 3'b100, 3'b001, 1, 0, 0));
        vt.push_back(mk("l3_preempt",   0, 3'b101, 3'b111, 3'b001, 3'b000, 1, 3'b100, 3'b100, 3'b001, 1, 1, 0));
        vt.push_back(mk("l3_ack",       0, 3'b101, 3'b111, 3'b101, 3'b000, 1, 3'b000, 3'b000, 3'b101, 3, 0, 0));
        vt.push_back(mk("l1_low",       0, 3'b100, 3'b111, 3'b101, 3'b000, 8, 3'b000, 3'b000, 3'b101, 3, 0, 0));
        vt.push_back(mk("l1_drop",      0, 3'b101, 3'b111, 3'b101, 3'b000, 8, 3'b000, 3'b000, 3'b101, 3, 0, 1));
        vt.push_back(mk("l3_done",      0, 3'b101, 3'b111, 3'b101, 3'b100, 1, 3'b000, 3'b000, 3'b001, 1, 0, 1));
        vt.push_back(mk("l3_run_fall",  0, 3'b101, 3'b111, 3'b001, 3'b000, 1, 3'b000, 3'b000, 3'b001, 1, 0, 1));
        vt.push_back(mk("reset2",       1, 3'b000, 3'b111, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vt.push_back(mk("both_pending", 0, 3'b101, 3'b111, 3'b000, 3'b000, 7, 3'b000, 3'b101, 3'b000, 0, 0, 0));
        vt.push_back(mk("both_req3",    0, 3'b101, 3'b111, 3'b000, 3'b000, 1, 3'b100, 3'b101, 3'b000, 0, 1, 0));
        vt.push_back(mk("both_ack3",    0, 3'b101, 3'b111, 3'b100, 3'b000, 1, 3'b000, 3'b001, 3'b100, 3, 0, 0));
        vt.push_back(mk("l1_blocked",   0, 3'b101, 3'b111, 3'b100, 3'b000, 4, 3'b000, 3'b001, 3'b100, 3, 0, 0));
        vt.push_back(mk("l3_done2",     0, 3'b101, 3'b111, 3'b100, 3'b100, 1, 3'b000, 3'b001, 3'b000, 0, 0, 0));
        vt.push_back(mk("l1_issue",     0, 3'b101, 3'b111, 3'b100, 3'b000, 1, 3'b001, 3'b001, 3'b000, 0, 1, 0));
        vt.push_back(mk("l1_ack2",      0, 3'b101, 3'b111, 3'b101, 3'b000, 1, 3'b000, 3'b000, 3'b001, 1, 0, 0));
        vt.push_back(mk("run_fall_all", 0, 3'b101, 3'b111, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vt.push_back(mk("reset3",       1, 3'b000, 3'b111, 3'b000, 3'b000, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0));
        vt.push_back(mk("l2_pending",   0, 3'b010, 3'b111, 3'b000, 3'b000, 7, 3'b000, 3'b010, 3'b000, 0, 0, 0));
        vt.push_back(mk("l2_req",       0, 3'b010, 3'b111, 3'b000, 3'b000, 1, 3'b010, 3'b010, 3'b000, 0, 1, 0));
        vt.push_back(mk("l2_req_last",  0, 3'b010, 3'b111, 3'b000, 3'b000, 7, 3'b010, 3'b010, 3'b000, 0, 1, 0));
        vt.push_back(mk("l2_timeout",   0, 3'b010, 3'b111, 3'b000, 3'b000, 1, 3'b000, 3'b000, 3'b000, 0, 0, 1));
        vt.push_back(mk("l2_no_retry",  0, 3'b010, 3'b111, 3'b000, 3'b000, 3, 3'b000, 3'b000, 3'b000, 0, 0, 1));

        foreach (vt[k]) begin
            apply(vt[k].rst, vt[k].raw, vt[k].mask, vt[k].run, vt[k].dn, vt[k].n);
            check(vt[k].name, vt[k].e_req, vt[k].e_pend, vt[k].e_isv, vt[k].e_act,
                  vt[k].e_busy, vt[k].e_drop);
        end

        // All levels in service; each raw toggle period drops three events at once.
        apply(0, 3'b000, 3'b111, 3'b111, 3'b000, 1);
        check("all_in_service", 3'b000, 3'b000, 3'b111, 3, 0, 1);
        apply(0, 3'b000, 3'b111, 3'b111, 3'b000, 8);
        check("all_low", 3'b000, 3'b000, 3'b111, 3, 0, 1);
        for (int p = 1; p <= 90; p++) begin
            apply(0, 3'b111, 3'b111, 3'b111, 3'b000, 8);
            apply(0, 3'b000, 3'b111, 3'b111, 3'b000, 8);
            if (p == 10) check("drop_30",  3'b000, 3'b000, 3'b111, 3, 0, 8'd31);
            if (p == 84) check("drop_253", 3'b000, 3'b000, 3'b111, 3, 0, 8'd253);
            if (p == 85) check("drop_sat", 3'b000, 3'b000, 3'b111, 3, 0, 8'd255);
        end
        check("drop_sat_hold", 3'b000, 3'b000, 3'b111, 3, 0, 8'd255);

        // Reset while a request is outstanding.
        apply(0, 3'b000, 3'b111, 3'b011, 3'b000, 1);
        check("l3_leaves", 3'b000, 3'b000, 3'b011, 2, 0, 8'd255);
        apply(0, 3'b100, 3'b111, 3'b011, 3'b000, 7);
        check("l3_pend_sat", 3'b000, 3'b100, 3'b011, 2, 0, 8'd255);
        apply(0, 3'b100, 3'b111, 3'b011, 3'b000, 1);
        check("l3_busy", 3'b100, 3'b100, 3'b011, 2, 1, 8'd255);
        apply(1, 3'b000, 3'b111, 3'b000, 3'b000, 1);
        check("rst_mid_req", 3'b000, 3'b000, 3'b000, 0, 0, 8'd0);

        // Masked event is discarded for good.
        apply(0, 3'b001, 3'b110, 3'b000, 3'b000, 10);
        check("masked_event", 3'b000, 3'b000, 3'b000, 0, 0, 8'd0);
        apply(0, 3'b001, 3'b111, 3'b000, 3'b000, 4);
        check("unmask_later", 3'b000, 3'b000, 3'b000, 0, 0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
